usb_token_sched: RTL and testbench

Host-side USB token scheduler. Sequences the 11-bit CRC5 datapath (one `usb_crc5_11` instance) to build 3-byte SOF, OUT, IN and SETUP token packets and streams them byte-wise to the host TX packetizer. It generates periodic SOF tokens from a frame timer and arbitrates them against transfer-engine token requests, with SOF taking priority. It also enforces an end-of-frame guard window.

---
 rtl/usb_token_sched.sv | 214 +++++++++++++++++++++
 tb/tb_usb_token_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_token_sched.sv
//------------------------------------------------------------------------------
// Module   : usb_token_sched (+ usb_crc5_11)
// Brief    : Host USB token scheduler: builds SOF/OUT/IN/SETUP tokens with
//            CRC5, periodic SOF timer, end-of-frame guard. Optional token
//            counter enabled by `define USB_TOKEN_SCHED_STATS_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module usb_crc5_11 (
    input  logic [10:0] data_in,
    output logic [4:0]  result
);
    logic [4:0] w_lfsr;

    always_comb begin
        w_lfsr = 5'h1f;
        for (int i = 0; i < 11; i++) begin
            if (data_in[i] ^ w_lfsr[4])
                w_lfsr = {w_lfsr[3:0], 1'b0} ^ 5'h05;
            else
                w_lfsr = {w_lfsr[3:0], 1'b0};
        end
        // Inverted and bit-reversed so result[0] is the first CRC bit on the wire
        result = ~{w_lfsr[0], w_lfsr[1], w_lfsr[2], w_lfsr[3], w_lfsr[4]};
    end
endmodule

module usb_token_sched #(
    parameter int SOF_PERIOD = 48000,
    parameter int GUARD      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_pid,
    input  logic [6:0]  req_addr,
    input  logic [3:0]  req_endp,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic [10:0] frame_num,
    output logic        sof_pulse,
    output logic        busy,
    output logic [15:0] tok_count
);
    localparam int CNT_W = $clog2(SOF_PERIOD);
    localparam logic [CNT_W-1:0] C_CNT_LOAD  = CNT_W'(SOF_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_GUARD     = CNT_W'(GUARD);
    localparam logic [7:0]       C_PID_OUT   = 8'hE1;
    localparam logic [7:0]       C_PID_IN    = 8'h69;
    localparam logic [7:0]       C_PID_SETUP = 8'h2D;
    localparam logic [7:0]       C_PID_SOF   = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PID  = 2'd1,
        S_B1   = 2'd2,
        S_B2   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sof_pending;
    logic             r_is_sof;
    logic [10:0]      r_f;
    logic [10:0]      r_frame_num;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_tx_last;
    logic             r_sof_pulse;
    logic [4:0]       w_crc;
    logic [7:0]       w_req_pid_byte;
    logic             w_idle;
    logic             w_guard;
    logic             w_sof_start;
    logic             w_req_acc;
    logic             w_hs;
    logic             w_tok_done;
    logic             w_sof_done;

    usb_crc5_11 u_crc (
        .data_in (r_f),
        .result  (w_crc)
    );

    assign w_idle      = (r_state == S_IDLE);
    assign w_guard     = sof_en && (r_cnt < C_GUARD);
    assign w_sof_start = w_idle && r_sof_pending;
    assign req_ready   = rst_n && w_idle && !r_sof_pending && !w_guard;
    assign w_req_acc   = req_valid && req_ready;
    assign w_hs        = r_tx_valid && tx_ready;
    assign w_tok_done  = (r_state == S_B2) && w_hs;
    assign w_sof_done  = w_tok_done && r_is_sof;
    assign busy        = !w_idle;

    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign tx_last   = r_tx_last;
    assign frame_num = r_frame_num;
    assign sof_pulse = r_sof_pulse;

    always_comb begin
        case (req_pid)
            2'b01:   w_req_pid_byte = C_PID_IN;
            2'b10:   w_req_pid_byte = C_PID_SETUP;
            default: w_req_pid_byte = C_PID_OUT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_sof_start || w_req_acc) w_state_nxt = S_PID;
            S_PID:   if (w_hs) w_state_nxt = S_B1;
            S_B1:    if (w_hs) w_state_nxt = S_B2;
            S_B2:    if (w_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output byte register: loaded one state ahead so tx_data is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f         <= '0;
            r_is_sof    <= 1'b0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_sof_pulse <= 1'b0;
            r_frame_num <= '0;
        end else begin
            r_sof_pulse <= w_sof_done;
            case (r_state)
                S_IDLE: begin
                    if (w_sof_start) begin
                        r_f        <= r_frame_num;
                        r_is_sof   <= 1'b1;
                        r_tx_data  <= C_PID_SOF;
                        r_tx_valid <= 1'b1;
                    end else if (w_req_acc) begin
                        r_f        <= {req_endp, req_addr};
                        r_is_sof   <= 1'b0;
                        r_tx_data  <= w_req_pid_byte;
                        r_tx_valid <= 1'b1;
                    end
                end
                S_PID: if (w_hs) r_tx_data <= r_f[7:0];
                S_B1: begin
                    if (w_hs) begin
                        r_tx_data <= {w_crc, r_f[10:8]};
                        r_tx_last <= 1'b1;
                    end
                end
                S_B2: begin
                    if (w_hs) begin
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (w_sof_done)
                r_frame_num <= r_frame_num + 11'd1;
        end
    end

    // A wrap with an SOF already owed simply keeps the single pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= C_CNT_LOAD;
            r_sof_pending <= 1'b0;
        end else if (!sof_en) begin
            r_cnt         <= C_CNT_LOAD;
            r_sof_pending <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt         <= C_CNT_LOAD;
            r_sof_pending <= 1'b1;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_sof_done)
                r_sof_pending <= 1'b0;
        end
    end

`ifdef USB_TOKEN_SCHED_STATS_EN
    logic [15:0] r_tok_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tok_count <= '0;
        else if (w_tok_done && (r_tok_count != 16'hFFFF))
            r_tok_count <= r_tok_count + 16'd1;
    end

    assign tok_count = r_tok_count;
`else
    assign tok_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_token_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_usb_token_sched
// Brief    : Directed vector bench for usb_token_sched (SOF_PERIOD=256, GUARD=64).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_usb_token_sched;
`ifdef USB_TOKEN_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof_en;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_pid;
    logic [6:0]  req_addr;
    logic [3:0]  req_endp;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic [10:0] frame_num;
    logic        sof_pulse;
    logic        busy;
    logic [15:0] tok_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_tok = 0;

    usb_token_sched #(.SOF_PERIOD(256), .GUARD(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof_en    (sof_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pid   (req_pid),
        .req_addr  (req_addr),
        .req_endp  (req_endp),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .frame_num (frame_num),
        .sof_pulse (sof_pulse),
        .busy      (busy),
        .tok_count (tok_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } vec_t;

    vec_t vt [6];

    // Reflected-form CRC5 (poly 0x14, shift right), LSB of the field first
    function automatic logic [4:0] crc_ref(input logic [10:0] f);
        logic [4:0] r;
        logic       fb;
        r = 5'h1f;
        for (int i = 0; i < 11; i++) begin
            fb = f[i] ^ r[0];
            r  = r >> 1;
            if (fb) r = r ^ 5'h14;
        end
        return ~r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called one step after the edge that put the PID byte out; tx_ready held high
    task automatic expect_token(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2);
        logic [23:0] bytes;
        bytes    = {b0, b1, b2};
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk({tag, " tx_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, " tx_data"}, 32'(tx_data), 32'(bytes[23-8*i -: 8]));
            chk({tag, " tx_last"}, 32'(tx_last), 32'(i == 2));
            chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
            tick();
        end
        exp_tok++;
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        chk({tag, " tok_count"}, 32'(tok_count), STATS ? 32'(exp_tok) : 32'd0);
    endtask

    task automatic send_req(input string tag, input vec_t v);
        req_pid   = v.pid;
        req_addr  = v.addr;
        req_endp  = v.endp;
        req_valid = 1'b1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        expect_token(tag, v.b0, v.b1, v.b2);
    endtask

    task automatic wait_tx(input string tag, input int limit, output int waited);
        waited = 0;
        while (!tx_valid && waited < limit) begin
            tick();
            waited++;
        end
        chk({tag, " wait tx_valid"}, 32'(tx_valid), 32'd1);
    endtask

    initial begin
        int   w;
        int   cnt;
        int   idx;
        bit   hs;
        vec_t v;
        logic [7:0]  bp [3];
        logic [3:0]  pat;

        vt[0] = '{2'd2, 7'h00, 4'h0, 8'h2D, 8'h00, 8'h10};
        vt[1] = '{2'd0, 7'h01, 4'h0, 8'hE1, 8'h01, {crc_ref(11'h001), 3'b000}};
        vt[2] = '{2'd1, 7'h7F, 4'hF, 8'h69, 8'hFF, {crc_ref(11'h7FF), 3'b111}};
        vt[3] = '{2'd3, 7'h15, 4'h3, 8'hE1, 8'h95, {crc_ref(11'h195), 3'b001}};
        vt[4] = '{2'd2, 7'h2A, 4'h8, 8'h2D, 8'h2A, {crc_ref(11'h42A), 3'b100}};
        vt[5] = '{2'd1, 7'h40, 4'h1, 8'h69, 8'hC0, {crc_ref(11'h0C0), 3'b000}};

        rst_n = 1'b0; sof_en = 1'b0; req_valid = 1'b0; req_pid = '0;
        req_addr = '0; req_endp = '0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst tx_valid", 32'(tx_valid), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst tx_last", 32'(tx_last), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_num", 32'(frame_num), 32'd0);
        chk("rst sof_pulse", 32'(sof_pulse), 32'd0);
        chk("rst tok_count", 32'(tok_count), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            send_req($sformatf("vec%0d", i), vt[i]);

        // Backpressure: ready pattern 1,0,0,1 repeating
        bp[0] = 8'h69; bp[1] = 8'hFF; bp[2] = {crc_ref(11'h7FF), 3'b111};
        pat = 4'b1001;
        req_pid = 2'd1; req_addr = 7'h7F; req_endp = 4'hF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 16 && idx < 3; c++) begin
            chk("bp tx_valid", 32'(tx_valid), 32'd1);
            chk("bp tx_data", 32'(tx_data), 32'(bp[idx]));
            chk("bp tx_last", 32'(tx_last), 32'(idx == 2));
            tx_ready = pat[c % 4];
            hs = tx_valid && tx_ready;
            tick();
            if (hs) idx++;
        end
        tx_ready = 1'b1;
        exp_tok++;
        chk("bp bytes sent", 32'(idx), 32'd3);
        chk("bp busy after", 32'(busy), 32'd0);

        // SOF cadence
        chk("sof frame_num before", 32'(frame_num), 32'd0);
        sof_en = 1'b1;
        wait_tx("sof0", 600, w);
        chk("sof0 latency", 32'(w), 32'd257);
        expect_token("sof0", 8'hA5, 8'h00, 8'h10);
        chk("sof0 pulse", 32'(sof_pulse), 32'd1);
        chk("sof0 frame_num", 32'(frame_num), 32'd1);
        tick();
        chk("sof0 pulse width", 32'(sof_pulse), 32'd0);
        wait_tx("sof1", 600, w);
        chk("sof period", 32'(w + 4), 32'd256);
        expect_token("sof1", 8'hA5, 8'h01, {crc_ref(11'h001), 3'b000});

        // Guard boundary: counter 64 then 63; then SOF priority over held request
        repeat (187) tick();
        chk("guard cnt64 ready", 32'(req_ready), 32'd1);
        tick();
        chk("guard cnt63 ready", 32'(req_ready), 32'd0);
        req_pid = 2'd1; req_addr = 7'h05; req_endp = 4'h2; req_valid = 1'b1;
        wait_tx("prio", 300, w);
        expect_token("prio sof", 8'hA5, 8'h02, {crc_ref(11'h002), 3'b000});
        chk("prio ready after sof", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        expect_token("prio req", 8'h69, 8'h05, {crc_ref(11'h105), 3'b001});

        // Frame number wrap
        force dut.r_frame_num = 11'd2047;
        tick();
        release dut.r_frame_num;
        wait_tx("wrap", 600, w);
        expect_token("wrap", 8'hA5, 8'hFF, {crc_ref(11'h7FF), 3'b111});
        chk("wrap frame_num", 32'(frame_num), 32'd0);

        // Disable during an SOF: it still completes, then no more SOFs
        wait_tx("dis", 600, w);
        sof_en = 1'b0;
        expect_token("dis", 8'hA5, 8'h00, 8'h10);
        chk("dis frame_num", 32'(frame_num), 32'd1);
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (tx_valid) cnt++;
        end
        chk("dis no sof", 32'(cnt), 32'd0);
        chk("dis frame kept", 32'(frame_num), 32'd1);

        // Reset mid-token during B1
        req_pid = 2'd0; req_addr = 7'h03; req_endp = 4'h1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid B1 byte", 32'(tx_data), 32'h83);
        tx_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid rst tx_valid", 32'(tx_valid), 32'd0);
        chk("mid rst tx_data", 32'(tx_data), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst req_ready", 32'(req_ready), 32'd0);
        chk("mid rst frame_num", 32'(frame_num), 32'd0);
        exp_tok = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        tick();
        chk("post rst tx_valid", 32'(tx_valid), 32'd0);
        chk("post rst tok_count", 32'(tok_count), 32'd0);
        v = vt[0];
        send_req("post rst", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
